// File: rtl/bcd_pkg.sv
// Shared BCD nibble type, limits and per-digit next-value helpers for the
// bcd_counter_n family.
package bcd_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;

   function automatic bcd_t bcd_clamp(input bcd_t nibble);
      bcd_t res;
      if (nibble > BCD_MAX) begin
         res = BCD_MAX;
      end else begin
         res = nibble;
      end
      return res;
   endfunction

   // Next value of one digit; load dominates, inc/dec are mutually exclusive.
   function automatic bcd_t bcd_next(input bcd_t q, input logic load,
                                     input bcd_t load_d, input logic inc,
                                     input logic dec);
      bcd_t res;
      if (load) begin
         res = bcd_clamp(load_d);
      end else if (inc) begin
         res = (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      end else if (dec) begin
         res = (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end else begin
         res = q;
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_counter_n_chk.sv
// Simulation checker for bcd_counter_n: digit range and carry/borrow exclusivity.
module bcd_counter_n_chk #(
   parameter int DIGITS = 2
) (
   input logic                  clk,
   input logic                  reset,
   input logic [4*DIGITS-1:0]   digits,
   input logic                  carry,
   input logic                  borrow
);

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      a_digit_range: assert property (@(posedge clk) disable iff (reset)
                                       digits[4*i +: 4] <= 4'd9);
   end

   a_carry_borrow_excl: assert property (@(posedge clk) disable iff (reset)
                                         !(carry && borrow));

endmodule

// File: rtl/bcd_digit.sv
// One registered BCD digit with combinational ripple to the next digit.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_d,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] q,
   output logic       ripple_out
);

   bcd_t q_r;

   // Digit state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_r <= BCD_MIN;
      end else begin
         q_r <= bcd_next(q_r, load, load_d, inc, dec);
      end
   end

   assign q          = q_r;
   assign ripple_out = ((q_r == BCD_MAX) && inc) || ((q_r == BCD_MIN) && dec);

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with load and wrap/saturate limits.
// Optional leading-zero blank mask output when BCD_COUNTER_BLANK_EN is defined.
module bcd_counter_n
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter bit WRAP   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  count_en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   output logic [4*DIGITS-1:0]   digits,
   output logic                  carry,
   output logic                  borrow
`ifdef BCD_COUNTER_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   logic [DIGITS-1:0] inc_s;
   logic [DIGITS-1:0] dec_s;
   logic [DIGITS-1:0] ripple_s;
   logic [DIGITS-1:0] max_s;
   logic [DIGITS-1:0] min_s;
   logic              cnt_up_s;
   logic              cnt_dn_s;
   logic              sat_up_s;
   logic              sat_dn_s;
   logic              carry_d_s;
   logic              borrow_d_s;
   logic              carry_r;
   logic              borrow_r;

   assign cnt_up_s = count_en && up && !load;
   assign cnt_dn_s = count_en && !up && !load;

   // In saturate mode a terminal attempt must not reach the digits at all.
   assign sat_up_s = !WRAP && cnt_up_s && (&max_s);
   assign sat_dn_s = !WRAP && cnt_dn_s && (&min_s);

   assign inc_s[0] = cnt_up_s && !sat_up_s;
   assign dec_s[0] = cnt_dn_s && !sat_dn_s;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign max_s[i] = (digits[4*i +: 4] == BCD_MAX);
      assign min_s[i] = (digits[4*i +: 4] == BCD_MIN);

      if (i > 0) begin : g_chain
         assign inc_s[i] = inc_s[i-1] && ripple_s[i-1];
         assign dec_s[i] = dec_s[i-1] && ripple_s[i-1];
      end

      bcd_digit u_digit (
         .clk        (clk),
         .reset      (reset),
         .load       (load),
         .load_d     (load_value[4*i +: 4]),
         .inc        (inc_s[i]),
         .dec        (dec_s[i]),
         .q          (digits[4*i +: 4]),
         .ripple_out (ripple_s[i])
      );
   end

   // A wrap shows up as ripple out of the top digit; a saturated attempt never ripples.
   assign carry_d_s  = (inc_s[DIGITS-1] && ripple_s[DIGITS-1]) || sat_up_s;
   assign borrow_d_s = (dec_s[DIGITS-1] && ripple_s[DIGITS-1]) || sat_dn_s;

   // Carry/borrow pulse registers, aligned with the digits they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carry_r  <= 1'b0;
         borrow_r <= 1'b0;
      end else begin
         carry_r  <= carry_d_s;
         borrow_r <= borrow_d_s;
      end
   end

   assign carry  = carry_r;
   assign borrow = borrow_r;

`ifdef BCD_COUNTER_BLANK_EN
   localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

   logic [3:0]        nxt_s [DIGITS];
   logic [DIGITS-1:0] blank_d_s;
   logic [DIGITS-1:0] blank_r;

   for (genvar i = 0; i < DIGITS; i++) begin : g_next
      assign nxt_s[i] = bcd_next(digits[4*i +: 4], load, load_value[4*i +: 4],
                                 inc_s[i], dec_s[i]);
   end

   // Leading-zero mask of the value the digits take on this edge; units never blank.
   always_comb begin
      logic zero_above_v;
      blank_d_s    = {DIGITS{1'b0}};
      zero_above_v = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above_v = zero_above_v && (nxt_s[i] == BCD_MIN);
         blank_d_s[i] = zero_above_v;
      end
   end

   // Blank mask register, updated together with the digits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blank_r <= BLANK_RST;
      end else begin
         blank_r <= blank_d_s;
      end
   end

   assign blank = blank_r;
`endif

   bcd_counter_n_chk #(
      .DIGITS (DIGITS)
   ) u_chk (
      .clk    (clk),
      .reset  (reset),
      .digits (digits),
      .carry  (carry_r),
      .borrow (borrow_r)
   );

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n: a wrap and a saturate instance share stimulus.
module tb_bcd_counter_n;

   logic       clk = 1'b0;
   logic       reset;
   logic       count_en;
   logic       up;
   logic       load;
   logic [7:0] load_value;
   logic [7:0] dig_w, dig_s;
   logic       carry_w, borrow_w, carry_s, borrow_s;

   int checks      = 0;
   int failures    = 0;
   int mv_w        = 0;
   int mv_s        = 0;
   int carry_cnt_w = 0;
   int carry_cnt_s = 0;

   logic [9:0] exp_q_w[$];
   logic [9:0] exp_q_s[$];

`ifdef BCD_COUNTER_BLANK_EN
   logic [1:0]  blank_w, blank_s;
   logic        load4;
   logic [15:0] lv4;
   logic [15:0] dig4;
   logic        carry4, borrow4;
   logic [3:0]  blank4;
`endif

   always #5 clk = ~clk;

   bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) dut_w (
      .clk        (clk),
      .reset      (reset),
      .count_en   (count_en),
      .up         (up),
      .load       (load),
      .load_value (load_value),
      .digits     (dig_w),
      .carry      (carry_w),
      .borrow     (borrow_w)
`ifdef BCD_COUNTER_BLANK_EN
      ,
      .blank      (blank_w)
`endif
   );

   bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) dut_s (
      .clk        (clk),
      .reset      (reset),
      .count_en   (count_en),
      .up         (up),
      .load       (load),
      .load_value (load_value),
      .digits     (dig_s),
      .carry      (carry_s),
      .borrow     (borrow_s)
`ifdef BCD_COUNTER_BLANK_EN
      ,
      .blank      (blank_s)
`endif
   );

`ifdef BCD_COUNTER_BLANK_EN
   bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) dut_4 (
      .clk        (clk),
      .reset      (reset),
      .count_en   (1'b0),
      .up         (1'b1),
      .load       (load4),
      .load_value (lv4),
      .digits     (dig4),
      .carry      (carry4),
      .borrow     (borrow4),
      .blank      (blank4)
   );
`endif

   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic int from_load(input logic [7:0] lv);
      int hi, lo;
      hi = int'(lv[7:4]);
      lo = int'(lv[3:0]);
      if (hi > 9) hi = 9;
      if (lo > 9) lo = 9;
      return hi * 10 + lo;
   endfunction

   // Integer reference model of a 2-digit counter.
   task automatic model(input bit wrap, inout int v, input logic ld,
                        input logic [7:0] lv, input logic en, input logic u,
                        output logic c, output logic b);
      c = 1'b0;
      b = 1'b0;
      if (ld) begin
         v = from_load(lv);
      end else if (en && u) begin
         if (v == 99) begin
            c = 1'b1;
            v = wrap ? 0 : 99;
         end else begin
            v = v + 1;
         end
      end else if (en && !u) begin
         if (v == 0) begin
            b = 1'b1;
            v = wrap ? 99 : 0;
         end else begin
            v = v - 1;
         end
      end
   endtask

   task automatic step(input logic ld, input logic [7:0] lv, input logic en,
                       input logic u);
      logic c, b;
      logic [9:0] e;
      load       = ld;
      load_value = lv;
      count_en   = en;
      up         = u;
      model(1'b1, mv_w, ld, lv, en, u, c, b);
      exp_q_w.push_back({c, b, to_bcd(mv_w)});
      model(1'b0, mv_s, ld, lv, en, u, c, b);
      exp_q_s.push_back({c, b, to_bcd(mv_s)});
      @(posedge clk);
      #1;
      e = exp_q_w.pop_front();
      check_value("sb_wrap", 32'({carry_w, borrow_w, dig_w}), 32'(e));
      e = exp_q_s.pop_front();
      check_value("sb_sat", 32'({carry_s, borrow_s, dig_s}), 32'(e));
      if (carry_w) carry_cnt_w++;
      if (carry_s) carry_cnt_s++;
   endtask

   initial begin
      reset      = 1'b1;
      count_en   = 1'b0;
      up         = 1'b1;
      load       = 1'b0;
      load_value = 8'h00;
`ifdef BCD_COUNTER_BLANK_EN
      load4 = 1'b0;
      lv4   = 16'h0000;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_value("reset_w", 32'({carry_w, borrow_w, dig_w}), 32'h0);
      check_value("reset_s", 32'({carry_s, borrow_s, dig_s}), 32'h0);
      reset = 1'b0;

      repeat (9) step(1'b0, 8'h00, 1'b1, 1'b1);
      check_value("up_09", 32'(dig_w), 32'h09);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      check_value("up_10", 32'(dig_w), 32'h10);
      repeat (89) step(1'b0, 8'h00, 1'b1, 1'b1);
      check_value("up_99", 32'(dig_w), 32'h99);
      check_value("carry_cnt_99", 32'(carry_cnt_w), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      check_value("wrap_00", 32'({carry_w, dig_w}), 32'h100);
      repeat (12) step(1'b0, 8'h00, 1'b1, 1'b1);
      check_value("up_12", 32'(dig_w), 32'h12);
      check_value("carry_cnt_12", 32'(carry_cnt_w), 32'd1);

      step(1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_value("dn_wrap_99", 32'({borrow_w, dig_w}), 32'h199);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_value("dn_98", 32'({borrow_w, dig_w}), 32'h098);

      step(1'b1, 8'h99, 1'b0, 1'b0);
      carry_cnt_s = 0;
      repeat (3) step(1'b0, 8'h00, 1'b1, 1'b1);
      check_value("sat_hold_99", 32'(dig_s), 32'h99);
      check_value("sat_carry_cnt", 32'(carry_cnt_s), 32'd3);
      step(1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_value("sat_hold_00", 32'({borrow_s, dig_s}), 32'h100);

      step(1'b1, 8'hF3, 1'b0, 1'b0);
      check_value("clamp_93", 32'(dig_w), 32'h93);
      step(1'b1, 8'h99, 1'b0, 1'b0);
      step(1'b1, 8'h99, 1'b1, 1'b1);
      check_value("load_wins", 32'({carry_w, carry_s, dig_w}), 32'h099);
      step(1'b1, 8'h45, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_value("hold_45", 32'({carry_w, borrow_w, dig_w}), 32'h045);

      repeat (4) step(1'b0, 8'h00, 1'b1, 1'b1);
      #3;
      reset = 1'b1;
      #1;
      check_value("async_rst_w", 32'({carry_w, borrow_w, dig_w}), 32'h0);
      check_value("async_rst_s", 32'({carry_s, borrow_s, dig_s}), 32'h0);
      #1;
      reset = 1'b0;
      mv_w  = 0;
      mv_s  = 0;
      step(1'b0, 8'h00, 1'b1, 1'b1);
      check_value("after_rst_01", 32'(dig_w), 32'h01);

`ifdef BCD_COUNTER_BLANK_EN
      reset = 1'b1;
      #1;
      check_value("blank_rst", 32'(blank4), 32'hE);
      reset = 1'b0;
      load4 = 1'b1;
      lv4   = 16'h0042;
      @(posedge clk);
      #1;
      check_value("blank_0042", 32'(blank4), 32'hC);
      lv4 = 16'h0000;
      @(posedge clk);
      #1;
      check_value("blank_0000", 32'(blank4), 32'hE);
      lv4 = 16'h1000;
      @(posedge clk);
      #1;
      check_value("blank_1000", 32'(blank4), 32'h0);
      load4 = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
- Parametrised N-digit BCD up/down counter with synchronous load, and selectable wrap or saturate at the limits.
- Successor to the fixed 2-digit up-only decade counter.
- Drives 7-segment/display muxes and timer chains; carry/borrow pulses cascade into further counters.

Parameters:
- DIGITS, 2, number of BCD digits; legal range 1..8.
- WRAP, 1, 1 = wrap 99..9↔00..0; 0 = saturate at the limits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- count_en  in  1  advance the count by one on this clock.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled with count_en.
- load  in  1  synchronous load of load_value.
- load_value  in  4*DIGITS  packed BCD value; digit 0 in bits [3:0].
- digits  out  4*DIGITS  packed BCD count; digit 0 (units) in bits [3:0].
- carry  out  1  registered pulse: increment past the maximum.
- borrow  out  1  registered pulse: decrement below zero.

Behaviour:
- Reset (asynchronous) sets digits=0, carry=0, borrow=0. Deassertion is synchronised externally.
- Priority per clock: load > count_en > hold.
- load: digits <= load_value next edge. Any nibble >9 loads as 9. carry=borrow=0 that cycle.
- count_en with up=1: digit 0 +1. A digit at 9 with ripple-in goes to 0 and ripples to the next digit. Combinational ripple, one-cycle latency.
- count_en with up=0: digit 0 −1. A digit at 0 with ripple-in goes to 9 and ripples. Both directions are symmetric.
- Count at all-9s with increment:
  - WRAP=1: digits → all-0, carry=1 for exactly one cycle, aligned with the first cycle digits shows 0.
  - WRAP=0: digits stay all-9, carry=1 for each such attempted cycle.
- Count at all-0 with decrement: same rules mirrored, using borrow; target is all-9 (WRAP=1) or hold 0 (WRAP=0).
- carry and borrow are never both high. Both are 0 on any cycle without count_en or with load.
- count_en=0: hold; carry=borrow=0.
- Internal digits are never outside 0..9 (invariant; assertion in simulation).
- Reset mid-count: immediate clear, independent of clk. The first count after release starts from 0.

Optional Feature:
- Macro: BCD_COUNTER_BLANK_EN.
- Defined: adds output blank [DIGITS-1:0]. Registered leading-zero mask, updated with digits (same cycle). Bit i=1 iff digit i and all higher digits are 0, and i≠0 (units never blanked). Reset value {DIGITS-1{1'b1}},1'b0.
- Undefined: port absent, no logic.

Decomposition:
- Package bcd_pkg:
  - BCD_W=4, BCD_MAX=4'd9, BCD_MIN=4'd0.
  - function bcd_clamp(nibble).
  - typedef bcd_t (logic [3:0]).
- Sub-module bcd_digit: one registered digit.
  - Inputs: clk, reset, load, load_d, inc, dec.
  - Outputs: q, ripple_out (q==9&inc or q==0&dec).
  - Instantiated DIGITS times via generate.
- Top: ripple chain, wrap/saturate gating, carry/borrow registers, optional blank mask.

Test Plan (DIGITS=2, WRAP=1 unless stated):
- Reset 3 clocks, release → digits=8'h00, carry=borrow=0. Then 9 increments → 8'h09; 1 more → 8'h10.
- From 8'h10, 89 increments → 8'h99, carry count 0. 1 more → 8'h00, carry high exactly one cycle. 12 more → 8'h12, carry count 1.
- Load 8'h00, 1 decrement → 8'h99, borrow one cycle. 1 decrement → 8'h98.
- WRAP=0: load 8'h99, 3 increments → stays 8'h99, carry high 3 cycles. Load 8'h00, decrement → 8'h00, borrow high.
- Load 8'hF3 → 8'h93. Load and count_en same cycle → load wins, carry=0. Async reset pulse mid-count between edges → digits 0 immediately.
- With BCD_COUNTER_BLANK_EN, DIGITS=4:
  - load 16'h0042 → blank=4'b1100.
  - load 16'h0000 → blank=4'b1110.
  - load 16'h1000 → blank=4'b0000.
